// File: rtl/banco_exec.sv
// banco_exec: single-issue execute/write-back controller driving the banco register bank
module banco_exec #(
  parameter int M = 32,
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [N-1:0] in_rs1,
  input  logic [N-1:0] in_rs2,
  input  logic [N-1:0] in_rd,
  output logic [N-1:0] rd_addr1,
  output logic [N-1:0] rd_addr2,
  input  logic [M-1:0] rd_data1,
  input  logic [M-1:0] rd_data2,
  output logic [N-1:0] wr_addr,
  output logic [M-1:0] wr_data,
  output logic         wr_en,
  output logic         done,
  output logic [M-1:0] result,
  output logic         zero
);
  localparam int SW = $clog2(M);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} stateT;
  stateT state;
  logic [2:0] op;
  logic [N-1:0] rd;
  logic [M-1:0] opA, opB, aluOut;
  // ALU over the captured operands; only the low shift bits of opB matter for SHL
  always_comb
    aluOut = op == 3'd0 ? opA + opB :
             op == 3'd1 ? opA - opB :
             op == 3'd2 ? opA & opB :
             op == 3'd3 ? opA | opB :
             op == 3'd4 ? opA ^ opB :
             op == 3'd5 ? {{(M-1){1'b0}}, $signed(opA) < $signed(opB)} :
             op == 3'd6 ? opA << opB[SW-1:0] : opA;
  // IDLE/WB accept -> READ captures operands -> EXEC registers result -> WB pulses the write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      wr_en <= 1'b0;
      done <= 1'b0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      result <= '0;
      zero <= 1'b1;
      op <= '0;
      rd <= '0;
      opA <= '0;
      opB <= '0;
    end else begin
      wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, WB:
          if (in_valid) begin
            op <= in_op;
            rd <= in_rd;
            rd_addr1 <= in_rs1;
            rd_addr2 <= in_rs2;
            in_ready <= 1'b0;
            state <= READ;
          end else begin
            in_ready <= 1'b1;
            state <= IDLE;
          end
        READ: begin
          opA <= rd_data1;
          opB <= rd_data2;
          state <= EXEC;
        end
        EXEC: begin
          result <= aluOut;
          zero <= aluOut == '0;
          wr_addr <= rd;
          wr_data <= aluOut;
          wr_en <= 1'b1;
          done <= 1'b1;
          in_ready <= 1'b1;
          state <= WB;
        end
      endcase
    end
endmodule

// File: tb/tb_banco_exec.sv
// tb_banco_exec: random and directed checks of banco_exec against a timeline model with a bank model
module tb_banco_exec;
  logic clk = 1'b0, rst = 1'b0;
  logic inValid;
  logic [2:0] inOp;
  logic [9:0] inRs1, inRs2, inRd;
  logic inReady, wrEn, done, zero;
  logic [9:0] rdAddr1, rdAddr2, wrAddr;
  logic [31:0] rdData1, rdData2, wrData, result;
  logic [31:0] mem [0:1023];
  logic [31:0] refRegs [0:1023];
  int total = 0, bad = 0;
  int ec, lastAcc, pendEdge, e1, e2;
  bit pv;
  logic [9:0] pendRd, eRd1, eRd2, eWrA;
  logic [31:0] pendVal, eWrD, eRes;
  logic eZero, mReady, mWrEn;

  banco_exec #(.M(32), .N(10)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_op(inOp),
    .in_rs1(inRs1), .in_rs2(inRs2), .in_rd(inRd), .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
    .rd_data1(rdData1), .rd_data2(rdData2), .wr_addr(wrAddr), .wr_data(wrData),
    .wr_en(wrEn), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  // bank: combinational read, write on the edge ending a write-enable cycle
  assign rdData1 = mem[rdAddr1];
  assign rdData2 = mem[rdAddr2];
  always @(posedge clk) if (wrEn) mem[wrAddr] = wrData;

  function automatic logic [31:0] aluRef(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a;
    endcase
  endfunction

  // timeline model: accept at edge a -> READ cycle a, EXEC a+1, WB a+2, bank write at edge a+3
  assign mReady = !(ec == lastAcc || ec == lastAcc + 1);
  assign mWrEn = ec == lastAcc + 2;
  always @(posedge clk or posedge rst)
    if (rst) begin
      ec = 0; lastAcc = -100; pendEdge = -100; pv = 0;
      eRd1 = 0; eRd2 = 0; eWrA = 0; eWrD = 0; eRes = 0; eZero = 1;
    end else begin
      automatic bit acc = inValid && mReady;
      ec++;
      if (pv && ec == pendEdge + 2) begin
        eWrA = pendRd; eWrD = pendVal; eRes = pendVal; eZero = pendVal == 0;
      end
      if (pv && ec == pendEdge + 3) begin
        refRegs[pendRd] = pendVal; pv = 0;
      end
      if (acc) begin
        lastAcc = ec; pendEdge = ec; pv = 1; pendRd = inRd;
        pendVal = aluRef(inOp, refRegs[inRs1], refRegs[inRs2]);
        eRd1 = inRs1; eRd2 = inRs2;
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("in_ready", {31'd0, inReady}, {31'd0, mReady});
    chk("wr_en", {31'd0, wrEn}, {31'd0, mWrEn});
    chk("done", {31'd0, done}, {31'd0, mWrEn});
    chk("rd_addr1", {22'd0, rdAddr1}, {22'd0, eRd1});
    chk("rd_addr2", {22'd0, rdAddr2}, {22'd0, eRd2});
    chk("wr_addr", {22'd0, wrAddr}, {22'd0, eWrA});
    chk("wr_data", wrData, eWrD);
    chk("result", result, eRes);
    chk("zero", {31'd0, zero}, {31'd0, eZero});
  end

  task automatic setReg(input int r, input logic [31:0] v);
    mem[r] = v;
    refRegs[r] = v;
  endtask

  task automatic issue(input logic [2:0] o, input logic [9:0] a, input logic [9:0] b, input logic [9:0] d, output int e);
    logic r;
    inOp = o; inRs1 = a; inRs2 = b; inRd = d; inValid = 1'b1; e = -1;
    for (int k = 0; k < 10 && e < 0; k++) begin
      @(negedge clk);
      r = inReady;
      @(posedge clk);
      #1;
      if (r) e = ec;
    end
    if (e < 0) begin
      total++; bad++;
      $display("FAIL accept-timeout: op %0d not accepted within 10 cycles", o);
    end
  endtask

  task automatic runOne(input string nm, input logic [2:0] o, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] d, input logic [31:0] expv, input logic expz);
    int e;
    issue(o, a, b, d, e);
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, " wr_en"}, {31'd0, wrEn}, 32'd1);
    chk({nm, " wr_data"}, wrData, expv);
    chk({nm, " zero"}, {31'd0, zero}, {31'd0, expz});
    chk({nm, " model"}, eWrD, expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) setReg(i, 32'd0);
    inValid = 0; inOp = 0; inRs1 = 0; inRs2 = 0; inRd = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {31'd0, inReady}, 32'd1);
    chk("reset wr_en", {31'd0, wrEn}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd1);
    chk("reset rd_addr1", {22'd0, rdAddr1}, 32'd0);
    chk("reset wr_addr", {22'd0, wrAddr}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    setReg(1, 32'd5); setReg(2, 32'd7);
    runOne("ADD", 3'd0, 10'd1, 10'd2, 10'd3, 32'd12, 1'b0);
    chk("bank r3", mem[3], 32'd12);
    setReg(1, 32'd1);
    runOne("SUB neg", 3'd1, 10'd0, 10'd1, 10'd6, 32'hFFFFFFFF, 1'b0);
    runOne("SUB zero", 3'd1, 10'd1, 10'd1, 10'd6, 32'd0, 1'b1);
    setReg(8, 32'hFFFFFFFF); setReg(9, 32'd1);
    runOne("SLT", 3'd5, 10'd8, 10'd9, 10'd10, 32'd1, 1'b0);
    setReg(11, 32'd1); setReg(12, 32'd33);
    runOne("SHL", 3'd6, 10'd11, 10'd12, 10'd10, 32'd2, 1'b0);
    runOne("PASS", 3'd7, 10'd2, 10'd8, 10'd10, 32'd7, 1'b0);
    setReg(13, 32'hF0F0); setReg(14, 32'h0FF0);
    runOne("XOR", 3'd4, 10'd13, 10'd14, 10'd10, 32'hFF00, 1'b0);
    setReg(1, 32'd5); setReg(2, 32'd7); setReg(3, 32'd0); setReg(4, 32'd0);
    issue(3'd0, 10'd1, 10'd2, 10'd3, e1);
    issue(3'd1, 10'd3, 10'd1, 10'd4, e2);
    inValid = 1'b0;
    chk("accept spacing", e2 - e1, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b r3", mem[3], 32'd12);
    chk("b2b r4", mem[4], 32'd7);
    setReg(5, 32'h55);
    issue(3'd0, 10'd1, 10'd2, 10'd5, e1);
    inValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst wr_en", {31'd0, wrEn}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", {31'd0, inReady}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rst r5 kept", mem[5], 32'h55);
    for (int r = 0; r < 16; r++) setReg(r, $urandom);
    for (int n = 0; n < 300; n++) begin
      issue(3'($urandom_range(0, 7)), 10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
            10'($urandom_range(0, 15)), e1);
      if ($urandom_range(0, 2) == 0) begin
        inValid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int r = 0; r < 16; r++) chk("final bank", mem[r], refRegs[r]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
